// File: rtl/pingpong_frame_sched.sv
// Two-bank ping-pong scheduler for the transpose frame buffer: issues write/read start pulses
// and tracks per-bank state. Define PINGPONG_SCHED_DROP_CNT_EN to add a saturating drop_cnt_o.
module pingpong_frame_sched #(
   parameter int unsigned ROW   = 64,
   parameter int unsigned CLO   = 2400,
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             frame_start_i,
   input  logic             wr_finish_i,
   input  logic             rd_ready_i,
   input  logic             rd_finish_i,
   output logic             wr_command_o,
   output logic             wr_bank_o,
   output logic             rd_command_o,
   output logic             rd_bank_o,
   output logic [1:0]       bank_full_o,
   output logic             frame_drop_o,
   output logic             busy_o
`ifdef PINGPONG_SCHED_DROP_CNT_EN
  ,output logic [CNT_W-1:0] drop_cnt_o
`endif
);

   typedef enum logic [1:0] {BkEmpty, BkWriting, BkFull, BkReading} bank_st_e;
   typedef enum logic {WIdle, WActive} wr_st_e;
   typedef enum logic {RIdle, RActive} rd_st_e;

   bank_st_e [1:0] bank_q, bank_d;
   wr_st_e         wr_st_q, wr_st_d;
   rd_st_e         rd_st_q, rd_st_d;
   logic           wr_bank_q, wr_bank_d;
   logic           rd_bank_q, rd_bank_d;
   logic           wr_cmd_q, wr_cmd_d;
   logic           rd_cmd_q, rd_cmd_d;
   logic           drop_q, drop_d;
   logic           busy_q, busy_d;

   // Frame geometry is informational only.
   logic unused_cfg;
   assign unused_cfg = ^{ROW[0], CLO[0], CNT_W[0]};

   always_comb begin
      bank_d    = bank_q;
      wr_st_d   = wr_st_q;
      rd_st_d   = rd_st_q;
      wr_bank_d = wr_bank_q;
      rd_bank_d = rd_bank_q;
      wr_cmd_d  = 1'b0;
      rd_cmd_d  = 1'b0;
      drop_d    = 1'b0;
      busy_d    = 1'b0;

      // Write side only touches an EMPTY/WRITING bank, read side only FULL/READING,
      // so the two FSMs never update the same bank in one cycle.
      case (wr_st_q)
         WIdle: begin
            if (frame_start_i) begin
               if (bank_q[wr_bank_q] == BkEmpty) begin
                  wr_cmd_d          = 1'b1;
                  bank_d[wr_bank_q] = BkWriting;
                  wr_st_d           = WActive;
               end else begin
                  drop_d = 1'b1;
               end
            end
         end
         WActive: begin
            if (frame_start_i) drop_d = 1'b1;
            if (wr_finish_i) begin
               bank_d[wr_bank_q] = BkFull;
               wr_bank_d         = ~wr_bank_q;
               wr_st_d           = WIdle;
            end
         end
         default: wr_st_d = WIdle;
      endcase

      case (rd_st_q)
         RIdle: begin
            if ((bank_q[rd_bank_q] == BkFull) && rd_ready_i) begin
               rd_cmd_d          = 1'b1;
               bank_d[rd_bank_q] = BkReading;
               rd_st_d           = RActive;
            end
         end
         RActive: begin
            if (rd_finish_i) begin
               bank_d[rd_bank_q] = BkEmpty;
               rd_bank_d         = ~rd_bank_q;
               rd_st_d           = RIdle;
            end
         end
         default: rd_st_d = RIdle;
      endcase

      for (int b = 0; b < 2; b++) begin
         if ((bank_d[b] == BkWriting) || (bank_d[b] == BkReading)) busy_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         bank_q    <= {BkEmpty, BkEmpty};
         wr_st_q   <= WIdle;
         rd_st_q   <= RIdle;
         wr_bank_q <= 1'b0;
         rd_bank_q <= 1'b0;
         wr_cmd_q  <= 1'b0;
         rd_cmd_q  <= 1'b0;
         drop_q    <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         bank_q    <= bank_d;
         wr_st_q   <= wr_st_d;
         rd_st_q   <= rd_st_d;
         wr_bank_q <= wr_bank_d;
         rd_bank_q <= rd_bank_d;
         wr_cmd_q  <= wr_cmd_d;
         rd_cmd_q  <= rd_cmd_d;
         drop_q    <= drop_d;
         busy_q    <= busy_d;
      end
   end

   assign wr_command_o   = wr_cmd_q;
   assign wr_bank_o      = wr_bank_q;
   assign rd_command_o   = rd_cmd_q;
   assign rd_bank_o      = rd_bank_q;
   assign bank_full_o[0] = (bank_q[0] == BkFull);
   assign bank_full_o[1] = (bank_q[1] == BkFull);
   assign frame_drop_o   = drop_q;
   assign busy_o         = busy_q;

`ifdef PINGPONG_SCHED_DROP_CNT_EN
   logic [CNT_W-1:0] drop_cnt_q;

   // Counts alongside the registered drop pulse so both update on the same edge.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         drop_cnt_q <= '0;
      end else if (drop_d && (drop_cnt_q != {CNT_W{1'b1}})) begin
         drop_cnt_q <= drop_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   assign drop_cnt_o = drop_cnt_q;
`endif

endmodule

// File: tb/tb_pingpong_frame_sched.sv
// Scoreboard bench for pingpong_frame_sched: a cycle model pushes expected outputs per step,
// popped and compared one edge later, plus directed checks of the key scenarios.
module tb_pingpong_frame_sched;

   localparam int CntW    = 16;
   localparam int Empty   = 0;
   localparam int Writing = 1;
   localparam int Full    = 2;
   localparam int Reading = 3;

   logic clk = 1'b0;
   logic rst = 1'b1, fs = 1'b0, wf = 1'b0, rr = 1'b0, rf = 1'b0;
   logic wr_command, wr_bank, rd_command, rd_bank, frame_drop, busy;
   logic [1:0] bank_full;
   logic [7:0] outs;
`ifdef PINGPONG_SCHED_DROP_CNT_EN
   logic [CntW-1:0] drop_cnt;
`endif

   int n_checks = 0;
   int n_errors = 0;

   logic [7:0]      exp_q[$];
   logic [CntW-1:0] exp_cnt_q[$];

   int m_bank[2];
   bit m_wact, m_ract, m_wb, m_rb;
   int m_cnt;

   pingpong_frame_sched #(
      .ROW   (64),
      .CLO   (2400),
      .CNT_W (CntW)
   ) dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .frame_start_i (fs),
      .wr_finish_i   (wf),
      .rd_ready_i    (rr),
      .rd_finish_i   (rf),
      .wr_command_o  (wr_command),
      .wr_bank_o     (wr_bank),
      .rd_command_o  (rd_command),
      .rd_bank_o     (rd_bank),
      .bank_full_o   (bank_full),
      .frame_drop_o  (frame_drop),
      .busy_o        (busy)
`ifdef PINGPONG_SCHED_DROP_CNT_EN
     ,.drop_cnt_o    (drop_cnt)
`endif
   );

   always #5 clk = ~clk;

   assign outs = {wr_command, wr_bank, rd_command, rd_bank, bank_full, frame_drop, busy};

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   // Drive one cycle of inputs, predict the post-edge outputs, then compare after the edge.
   task automatic step(input bit r, input bit s, input bit f, input bit ready, input bit rfin);
      int         nb[2];
      bit         wc, rc, dr, bz;
      logic [1:0] bf;
      logic [7:0] e;
      rst = r; fs = s; wf = f; rr = ready; rf = rfin;
      if (r) begin
         m_bank = '{Empty, Empty};
         m_wact = 0; m_ract = 0; m_wb = 0; m_rb = 0; m_cnt = 0;
         e = 8'h00;
      end else begin
         nb = m_bank;
         wc = 0; rc = 0; dr = 0;
         if (!m_wact) begin
            if (s && m_bank[m_wb] == Empty) begin
               wc = 1; nb[m_wb] = Writing; m_wact = 1;
            end else if (s) begin
               dr = 1;
            end
         end else begin
            dr = s;
            if (f) begin
               nb[m_wb] = Full; m_wb = !m_wb; m_wact = 0;
            end
         end
         if (!m_ract) begin
            if (ready && m_bank[m_rb] == Full) begin
               rc = 1; nb[m_rb] = Reading; m_ract = 1;
            end
         end else if (rfin) begin
            nb[m_rb] = Empty; m_rb = !m_rb; m_ract = 0;
         end
         m_bank = nb;
         if (dr && m_cnt < 65535) m_cnt++;
         bf = {nb[1] == Full, nb[0] == Full};
         bz = (nb[0] == Writing) || (nb[0] == Reading) || (nb[1] == Writing) || (nb[1] == Reading);
         e = {wc, m_wb, rc, m_rb, bf, dr, bz};
      end
      exp_q.push_back(e);
      exp_cnt_q.push_back(m_cnt[CntW-1:0]);
      @(posedge clk);
      #1;
      check_eq("outs", outs, exp_q.pop_front());
`ifdef PINGPONG_SCHED_DROP_CNT_EN
      check_eq("drop_cnt", drop_cnt, exp_cnt_q.pop_front());
`else
      void'(exp_cnt_q.pop_front());
`endif
   endtask

   task automatic do_reset();
      step(1, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0);
   endtask

   initial begin
      // Single frame through write then read
      do_reset();
      check_eq("reset_outs", outs, 8'h00);
      step(0, 1, 0, 0, 0);
      check_eq("t1_wrcmd", wr_command, 1);
      check_eq("t1_wrbank", wr_bank, 0);
      step(0, 0, 0, 0, 0);
      check_eq("t1_pulse", wr_command, 0);
      step(0, 0, 0, 0, 0);
      step(0, 0, 1, 1, 0);
      check_eq("t1_full", bank_full, 2'b01);
      check_eq("t1_wrbank_tog", wr_bank, 1);
      check_eq("t1_no_rdcmd_yet", rd_command, 0);
      step(0, 0, 0, 1, 0);
      check_eq("t1_rdcmd", rd_command, 1);
      check_eq("t1_rdbank", rd_bank, 0);

      // Back-to-back: write bank 1 while bank 0 is read
      step(0, 1, 0, 0, 0);
      check_eq("t2_wrcmd", wr_command, 1);
      check_eq("t2_wrbank", wr_bank, 1);
      step(0, 0, 0, 0, 0);
      step(0, 0, 1, 0, 0);
      check_eq("t2_full1", bank_full, 2'b10);
      step(0, 0, 0, 0, 1);
      check_eq("t2_rdfin_full", bank_full, 2'b10);
      check_eq("t2_rdbank", rd_bank, 1);
      step(0, 0, 0, 1, 0);
      check_eq("t2_rdcmd1", rd_command, 1);
      step(0, 0, 0, 0, 1);
      check_eq("t2_idle", outs, 8'h00);

      // Three frames with no reader: third is dropped
      step(0, 1, 0, 0, 0);
      step(0, 0, 1, 0, 0);
      step(0, 1, 0, 0, 0);
      step(0, 0, 1, 0, 0);
      step(0, 1, 0, 0, 0);
      check_eq("t3_drop", frame_drop, 1);
      check_eq("t3_no_wrcmd", wr_command, 0);
      check_eq("t3_full", bank_full, 2'b11);
`ifdef PINGPONG_SCHED_DROP_CNT_EN
      check_eq("t3_cnt", drop_cnt, 1);
`endif

      // frame_start coinciding with wr_finish
      do_reset();
      step(0, 1, 0, 0, 0);
      step(0, 1, 1, 0, 0);
      check_eq("t4_drop", frame_drop, 1);
      check_eq("t4_full", bank_full, 2'b01);
      step(0, 1, 0, 0, 0);
      check_eq("t4_wrcmd", wr_command, 1);
      check_eq("t4_wrbank", wr_bank, 1);

      // Reset while one bank writes and the other reads
      do_reset();
      step(0, 1, 0, 0, 0);
      step(0, 0, 1, 0, 0);
      step(0, 0, 0, 1, 0);
      step(0, 1, 0, 0, 0);
      check_eq("t5_busy", busy, 1);
      step(1, 0, 0, 0, 0);
      check_eq("t5_rst", outs, 8'h00);
      step(0, 0, 1, 0, 1);
      check_eq("t5_stray", outs, 8'h00);

      // Simultaneous wr_finish/rd_finish, then rd_finish freeing the targeted bank
      do_reset();
      step(0, 1, 0, 0, 0);
      step(0, 0, 1, 0, 0);
      step(0, 0, 0, 1, 0);
      step(0, 1, 0, 0, 0);
      step(0, 0, 1, 0, 1);
      check_eq("t7_both_full", bank_full, 2'b10);
      check_eq("t7_both_rb", rd_bank, 1);
      step(0, 0, 0, 1, 0);
      check_eq("t7_rdcmd", rd_command, 1);
      step(0, 1, 0, 0, 0);
      step(0, 0, 1, 0, 0);
      step(0, 1, 0, 0, 1);
      check_eq("t7_race_drop", frame_drop, 1);
      check_eq("t7_race_nowc", wr_command, 0);
      step(0, 1, 0, 0, 0);
      check_eq("t7_retry_wc", wr_command, 1);

`ifdef PINGPONG_SCHED_DROP_CNT_EN
      // Saturation of the drop counter
      do_reset();
      step(0, 1, 0, 0, 0);
      for (int i = 0; i < 70000; i++) step(0, 1, 0, 0, 0);
      check_eq("t6_sat", drop_cnt, 16'hFFFF);
`endif

      step(0, 0, 0, 0, 0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
